// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: in-order reorder-buffer controller feeding a renaming register file.
// Allocates tags at issue, records CDB completions, retires in program order.
// Optional macro ROB_CDB_BYPASS_EN: a CDB broadcast hitting the waiting head
// entry retires it in the same cycle (zero-cycle completion-to-commit).
module rob_commit_ctrl #(
  parameter int unsigned ROB_WIDTH = 3,
  parameter int unsigned REG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 issue_req,
  input  logic [REG_WIDTH-1:0] issue_reg,
  output logic                 issue_ack,
  output logic [ROB_WIDTH-1:0] issue_tag,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_data,
  output logic                 commit,
  output logic [ROB_WIDTH-1:0] commit_tag,
  output logic [REG_WIDTH-1:0] commit_reg,
  output logic [31:0]          commit_data,
  output logic [ROB_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned DEPTH = 2 ** ROB_WIDTH;
  localparam int unsigned CW    = ROB_WIDTH + 1;

  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [DEPTH-1:0]     done_q, done_d;
  logic [REG_WIDTH-1:0] reg_q  [DEPTH];
  logic [31:0]          data_q [DEPTH];
  logic [ROB_WIDTH-1:0] head_q, head_d;
  logic [ROB_WIDTH-1:0] tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 cdb_hit_c;
  logic                 bypass_c;

  // Completions only land on entries that are still allocated.
  assign cdb_hit_c = cdb_valid & busy_q[cdb_tag];

`ifdef ROB_CDB_BYPASS_EN
  // Head is waiting on exactly this broadcast: retire it straight from the CDB.
  assign bypass_c = cdb_valid & busy_q[head_q] & ~done_q[head_q] & (cdb_tag == head_q);
`else
  assign bypass_c = 1'b0;
`endif

  // Status and handshake outputs; issue is refused when full even if the head retires.
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign issue_ack   = issue_req & ~full & ~flush;
  assign issue_tag   = tail_q;
  assign commit      = busy_q[head_q] & (done_q[head_q] | bypass_c) & ~flush;
  assign commit_tag  = head_q;
  assign commit_reg  = reg_q[head_q];
  assign commit_data = bypass_c ? cdb_data : data_q[head_q];

  // Next-state for entry flags, pointers and occupancy; allocation is applied last so it wins.
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cdb_hit_c) begin
        done_d[cdb_tag] = 1'b1;
      end
      if (commit) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + ROB_WIDTH'(1);
      end
      if (issue_ack) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        tail_d         = tail_q + ROB_WIDTH'(1);
      end
      case ({issue_ack, commit})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage (not reset): destination register at issue, result at completion.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (issue_ack) begin
        reg_q[tail_q] <= issue_reg;
      end
      if (cdb_hit_c) begin
        data_q[cdb_tag] <= cdb_data;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed self-checking bench for rob_commit_ctrl (default and ROB_CDB_BYPASS_EN builds).
module tb_rob_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        issue_req = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic        issue_ack;
  logic [2:0]  issue_tag;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        commit;
  logic [2:0]  commit_tag;
  logic [4:0]  commit_reg;
  logic [31:0] commit_data;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int total = 0;
  int bad   = 0;

  rob_commit_ctrl #(.ROB_WIDTH(3), .REG_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .issue_req  (issue_req),
    .issue_reg  (issue_reg),
    .issue_ack  (issue_ack),
    .issue_tag  (issue_tag),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .commit     (commit),
    .commit_tag (commit_tag),
    .commit_reg (commit_reg),
    .commit_data(commit_data),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    // Reset values while rst is held
    #3;
    chk("rst_commit", 32'(commit), 0);
    chk("rst_ack", 32'(issue_ack), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_issue_tag", 32'(issue_tag), 0);
    chk("rst_commit_tag", 32'(commit_tag), 0);
    chk("rst_count", 32'(count), 0);
    tick();
    rst = 1'b0;

    // 1: three issues
    issue_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_reg = 5'(i + 1);
      #1;
      chk("t1_ack", 32'(issue_ack), 1);
      chk("t1_tag", 32'(issue_tag), 32'(i));
      tick();
    end
    issue_req = 1'b0;
    #1;
    chk("t1_count", 32'(count), 3);
    chk("t1_empty", 32'(empty), 0);
    chk("t1_commit", 32'(commit), 0);

    // 2: out-of-order completion, in-order retirement
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'hAAAA;
    #1;
    chk("t2_nocommit_a", 32'(commit), 0);
    tick();
    cdb_tag = 3'd0; cdb_data = 32'h5555;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("t2_byp_commit", 32'(commit), 1);
    chk("t2_byp_data", commit_data, 32'h5555);
    chk("t2_byp_reg", 32'(commit_reg), 1);
    tick();
    cdb_valid = 1'b0;
    #1;
`else
    chk("t2_nocommit_b", 32'(commit), 0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("t2_c0_commit", 32'(commit), 1);
    chk("t2_c0_tag", 32'(commit_tag), 0);
    chk("t2_c0_data", commit_data, 32'h5555);
    chk("t2_c0_reg", 32'(commit_reg), 1);
    tick();
`endif
    chk("t2_c1_commit", 32'(commit), 1);
    chk("t2_c1_tag", 32'(commit_tag), 1);
    chk("t2_c1_data", commit_data, 32'hAAAA);
    chk("t2_c1_reg", 32'(commit_reg), 2);
    tick();
    chk("t2_idle", 32'(commit), 0);
    chk("t2_count", 32'(count), 1);
    do_flush();
    #1;
    chk("t2_flush_count", 32'(count), 0);

    // 3: fill to full, refuse, wrap
    issue_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue_reg = 5'(i + 4);
      #1;
      chk("t3_fill_tag", 32'(issue_tag), 32'(i));
      tick();
    end
    chk("t3_full", 32'(full), 1);
    chk("t3_count", 32'(count), 8);
    chk("t3_refuse", 32'(issue_ack), 0);
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h77;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("t3_commit", 32'(commit), 1);
    chk("t3_noack", 32'(issue_ack), 0);
    tick();
    cdb_valid = 1'b0;
    #1;
`else
    chk("t3_noack_a", 32'(issue_ack), 0);
    chk("t3_nocommit", 32'(commit), 0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("t3_commit", 32'(commit), 1);
    chk("t3_noack", 32'(issue_ack), 0);
    chk("t3_commit_data", commit_data, 32'h77);
    tick();
`endif
    chk("t3_ack_wrap", 32'(issue_ack), 1);
    chk("t3_tag_wrap", 32'(issue_tag), 0);
    chk("t3_count7", 32'(count), 7);
    tick();
    issue_req = 1'b0;
    #1;
    chk("t3_count8", 32'(count), 8);
    do_flush();

    // 4: flush beats concurrent issue and completion
    issue_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue_reg = 5'(i + 20);
      tick();
    end
    issue_req = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'h11;
    tick();
    cdb_tag = 3'd2; cdb_data = 32'h22;
    tick();
    flush = 1'b1; issue_req = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h99;
    #1;
    chk("t4_count5", 32'(count), 5);
    chk("t4_commit", 32'(commit), 0);
    chk("t4_ack", 32'(issue_ack), 0);
    tick();
    flush = 1'b0; issue_req = 1'b0; cdb_valid = 1'b0;
    #1;
    chk("t4_count", 32'(count), 0);
    chk("t4_empty", 32'(empty), 1);
    chk("t4_tag", 32'(issue_tag), 0);
    chk("t4_nocommit", 32'(commit), 0);

    // 5: completion-to-commit latency at the head
    issue_req = 1'b1; issue_reg = 5'd9;
    tick();
    issue_req = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h1234;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("t5_byp_commit", 32'(commit), 1);
    chk("t5_byp_data", commit_data, 32'h1234);
    chk("t5_byp_reg", 32'(commit_reg), 9);
    tick();
    cdb_valid = 1'b0;
`else
    chk("t5_nocommit", 32'(commit), 0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("t5_commit", 32'(commit), 1);
    chk("t5_data", commit_data, 32'h1234);
    chk("t5_reg", 32'(commit_reg), 9);
    tick();
`endif
    #1;
    chk("t5_empty", 32'(empty), 1);
    chk("t5_commit_tag", 32'(commit_tag), 1);

    // 6: asynchronous reset mid-stream
    issue_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_reg = 5'(i + 10);
      tick();
    end
    issue_req = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'hB2;
    tick();
    cdb_tag = 3'd1; cdb_data = 32'hB1;
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("t6_pending", 32'(commit), 1);
    chk("t6_pending_data", commit_data, 32'hB1);
    rst = 1'b1;
    #1;
    chk("t6_commit", 32'(commit), 0);
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_full", 32'(full), 0);
    chk("t6_issue_tag", 32'(issue_tag), 0);
    chk("t6_commit_tag", 32'(commit_tag), 0);
    chk("t6_ack", 32'(issue_ack), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_commit", 32'(commit), 0);
    chk("t6_post_empty", 32'(empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
In-order reorder-buffer controller that sequences the renaming register file.
- Allocates ROB tags at issue and records result completions from the CDB.
- Retires entries strictly in program order.
- Drives the register file's issue_tag and commit/commit_tag/commit_data inputs.
- Sits between the decode/issue stage, the CDB and the register file.

Parameters:
ROB_WIDTH, 3, log2 of entry count (DEPTH = 2**ROB_WIDTH = 8)
REG_WIDTH, 5, architectural register index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  discard all entries (misprediction recovery)
issue_req  in  1  decode requests a new entry
issue_reg  in  REG_WIDTH  destination register of issuing instruction
issue_ack  out  1  allocation accepted this cycle
issue_tag  out  ROB_WIDTH  tag allocated (current tail)
cdb_valid  in  1  completion broadcast valid
cdb_tag  in  ROB_WIDTH  tag of completing entry
cdb_data  in  32  result value
commit  out  1  head entry retires this cycle
commit_tag  out  ROB_WIDTH  tag of retiring entry
commit_reg  out  REG_WIDTH  destination register of retiring entry
commit_data  out  32  result of retiring entry
count  out  ROB_WIDTH+1  occupied entries, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. While rst is asserted, head = tail = 0, count = 0, and every entry has busy = 0 and done = 0. Outputs are commit = 0, issue_ack = 0, full = 0, empty = 1, issue_tag = 0, commit_tag = 0. Data fields are not reset.
- Entry state: each entry holds busy, done, reg[REG_WIDTH-1:0] and data[31:0].
- Pointers: head and tail are ROB_WIDTH bits and wrap modulo DEPTH. count disambiguates head == tail (empty vs full).
- Issue, combinational:
  - issue_ack = issue_req & !full & !flush.
  - issue_tag = tail at all times.
- Issue, at the edge when issue_ack: entry[tail] gets busy = 1, done = 0, reg = issue_reg; tail increments.
- Completion, at the edge when cdb_valid and entry[cdb_tag].busy: entry gets done = 1, data = cdb_data.
  - A CDB hit on a non-busy entry is ignored.
  - If the allocation and the completion target the same index, the allocation wins (done = 0).
- Commit, combinational:
  - commit = entry[head].busy & entry[head].done & !flush.
  - commit_tag = head; commit_reg = entry[head].reg; commit_data = entry[head].data.
- Commit, at the edge when commit: entry[head].busy = 0; head increments.
- Latency: CDB at edge N gives commit asserted in cycle N+1 at the earliest; one retirement per cycle maximum.
- count update: +1 on issue_ack only, -1 on commit only, unchanged when both occur.
- Full boundary: issue is refused when full, even if a commit happens in the same cycle. No same-cycle slot reuse.
- Empty boundary: commit is never asserted (head not busy).
- Flush, synchronous, has priority over all other events: all busy cleared, head = tail = 0, count = 0. issue_ack and commit are forced to 0 in the flush cycle; the CDB is ignored.
- Reset mid-operation: rst asserted asynchronously clears state immediately, regardless of in-flight issue or commit.
- Register-file contract: the owner feeds issue_ack to the register file's issue and issue_tag to its issue_tag. commit, commit_tag and commit_data connect directly.

Optional Feature:
Macro ROB_CDB_BYPASS_EN.
- With the macro defined: if entry[head] is busy and not done, cdb_valid is asserted and cdb_tag == head, then in that same cycle:
  - commit = 1 and commit_data = cdb_data;
  - head advances at the edge.
  Zero-cycle completion-to-commit.
- Without the macro: such a completion only sets done, and commit occurs in the next cycle.

Test Plan:
1. Reset, then issue 3 times (regs 1, 2, 3) -> issue_tag 0, 1, 2; count = 3; empty = 0; commit = 0.
2. CDB tag 1 data 0xAAAA, then tag 0 data 0x5555 -> no commit after the first; the cycle after the second: commit tag 0 data 0x5555 reg 1, next cycle commit tag 1 data 0xAAAA reg 2.
3. Issue 8 with none complete -> full = 1, count = 8; 9th issue_req gives issue_ack = 0. Complete tag 0 with issue_req held -> commit and no ack in the same cycle; ack next cycle with issue_tag 0 (wrap).
4. Fill to 5 entries, complete 2, assert flush concurrent with issue_req and cdb_valid -> commit = 0, issue_ack = 0; next cycle count = 0, empty = 1, issue_tag = 0.
5. ROB_CDB_BYPASS_EN: 1 entry at head tag 0, CDB tag 0 data 0x1234 -> commit = 1 with commit_data 0x1234 in the same cycle. Without the macro, commit occurs one cycle later.
6. Assert rst asynchronously mid-stream (4 entries, commit pending) -> outputs drop to reset values before the next clk edge; count = 0.
